ccg_sweep_ctrl: RTL
===================

CCG_SWEEP_CTRL -- requirements
Module: ccg_sweep_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 5, number of netlist primary inputs swept.
REQ-002 SHALL have parameter N_OUT, default 12, number of netlist outputs compared.
REQ-003 SHALL have parameter SETTLE_CYC, default 1, range 0..15, wait cycles between driving a vector and sampling outputs.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: start  in  1  run request pulse; abort  in  1  stop current run.
REQ-006 SHALL have ports: x_vec  out  N_IN  vector driven to both netlists.
REQ-007 SHALL have ports: f_ref  in  N_OUT  golden netlist outputs; f_dut  in  N_OUT  resynthesised netlist outputs.
REQ-008 SHALL have ports: busy  out  1; done  out  1  completion pulse; aborted  out  1  last run aborted.
REQ-009 SHALL have ports: mismatch_cnt  out  N_IN+1  failing vectors; first_fail_vec  out  N_IN; first_fail_mask  out  N_OUT  f_ref^f_dut at first failure; signature  out  16  MISR of f_dut.

Function
REQ-010 SHALL implement FSM states IDLE, DRIVE, SETTLE, CAPTURE, FINISH.
REQ-011 IDLE: start=1 SHALL clear x_vec, mismatch_cnt, first_fail_*, aborted, load signature=16'hFFFF, go to DRIVE next cycle.
REQ-012 DRIVE SHALL last 1 cycle with x_vec stable, then go to SETTLE if SETTLE_CYC>0, else CAPTURE.
REQ-013 SETTLE SHALL last exactly SETTLE_CYC cycles using a 4-bit down-counter, then go to CAPTURE.
REQ-014 CAPTURE SHALL, in 1 cycle, sample f_ref/f_dut, compare, update MISR and counters.
REQ-015 On f_ref!=f_dut in CAPTURE, mismatch_cnt SHALL increment; if it was 0, first_fail_vec=x_vec and first_fail_mask=f_ref^f_dut.
REQ-016 MISR update SHALL be sig <= {sig[14:0], sig[15]^sig[14]^sig[12]^sig[3]} ^ zero-extended f_dut.
REQ-017 After CAPTURE, if x_vec=2^N_IN-1 go to FINISH, else x_vec+1 and go to DRIVE; x_vec SHALL not wrap to 0.
REQ-018 Run length from start-accept cycle to done SHALL be 2^N_IN*(2+SETTLE_CYC)+1 cycles (97 at defaults).
REQ-019 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 start while busy SHALL be ignored, with no effect on the run.
REQ-022 abort=1 in any non-IDLE state SHALL take priority over all transitions: go to IDLE next cycle, aborted=1, done not asserted, and the CAPTURE update of that cycle discarded.
REQ-023 abort and start together in IDLE: start SHALL win; abort in IDLE SHALL be ignored.
REQ-024 Result outputs SHALL hold their values from run end until the next accepted start.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE; x_vec=0, busy=0, done=0, aborted=0, mismatch_cnt=0, first_fail_vec=0, first_fail_mask=0, signature=16'hFFFF.
REQ-026 Reset mid-run SHALL abandon the run without a done pulse; aborted SHALL stay 0.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, MISR width 16, seed 16'hFFFF and tap constants.
REQ-028 The MISR SHALL be a separate sub-module ccg_misr16 (clk, rst_n, init, en, din[15:0], sig[15:0]).
REQ-029 All outputs SHALL be registered; no combinational path from f_ref/f_dut to any output.

Verification
REQ-030 f_dut tied to f_ref, SETTLE_CYC=1, start pulse -> done exactly 97 cycles later, mismatch_cnt=0, first_fail_mask=0, x_vec ends at 31.
REQ-031 f_dut=f_ref except bit 3 flipped when x_vec=9 -> mismatch_cnt=1, first_fail_vec=9, first_fail_mask=12'h008.
REQ-032 Flips at vectors 4 and 20 -> mismatch_cnt=2, first_fail_vec=4; signature matches the bench reference MISR model.
REQ-033 abort asserted during CAPTURE of vector 10 -> IDLE next cycle, aborted=1, no done, mismatch_cnt excludes vector 10.
REQ-034 start pulsed at cycle 40 of a run, and rst_n=0 at cycle 50 of a second run -> first run unaffected (done at 97); second run leaves all REQ-025 values and no done.
REQ-035 SETTLE_CYC=0 and SETTLE_CYC=15 -> done at 65 and 545 cycles respectively.

Source files
------------

// File: rtl/ccg_sweep_ctrl_pkg.sv
// Shared types and constants for the netlist equivalence sweep controller.
package ccg_sweep_ctrl_pkg;

  // Sweep controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  // Signature register geometry: polynomial taps at bits 15, 14, 12 and 3
  localparam int                MISR_W    = 16;
  localparam logic [MISR_W-1:0] MISR_SEED = 16'hFFFF;
  localparam logic [MISR_W-1:0] MISR_TAPS = 16'hD008;

  // Width of the settle down-counter (SETTLE_CYC is limited to 0..15)
  localparam int SETTLE_W = 4;

  // One MISR step: shift left, feed back the XOR of the tapped bits, fold in the data word
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                  input logic [MISR_W-1:0] din);
    return {sig[MISR_W-2:0], ^(sig & MISR_TAPS)} ^ din;
  endfunction

endpackage

// File: rtl/ccg_sweep_ctrl_if.sv
// Bus between the sweep controller and the host / netlist harness.
interface ccg_sweep_ctrl_if #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 12
);
  import ccg_sweep_ctrl_pkg::*;

  logic              start;
  logic              abort;
  logic [N_IN-1:0]   x_vec;
  logic [N_OUT-1:0]  f_ref;
  logic [N_OUT-1:0]  f_dut;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [N_IN:0]     mismatch_cnt;
  logic [N_IN-1:0]   first_fail_vec;
  logic [N_OUT-1:0]  first_fail_mask;
  logic [MISR_W-1:0] signature;

  // Host side: requests runs and feeds back both netlists' responses
  modport master (
    output start, abort, f_ref, f_dut,
    input  x_vec, busy, done, aborted, mismatch_cnt, first_fail_vec, first_fail_mask, signature
  );

  // Controller side
  modport slave (
    input  start, abort, f_ref, f_dut,
    output x_vec, busy, done, aborted, mismatch_cnt, first_fail_vec, first_fail_mask, signature
  );

endinterface

// File: rtl/ccg_misr16.sv
// 16-bit multiple-input signature register compacting the resynthesised netlist outputs.
module ccg_misr16
  import ccg_sweep_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              en,
  input  logic [MISR_W-1:0] din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] sig_d;

  // Next signature: reseed has priority over a compaction step
  always_comb begin
    sig_d = sig_q;
    if (init) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = misr_next(sig_q, din);
    end
  end

  // Signature register, reset to the seed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/ccg_sweep_ctrl.sv
// Exhaustive input sweep comparing a golden and a resynthesised netlist.
// Every input vector is driven, allowed to settle, then both output words
// are compared and the resynthesised outputs are folded into a MISR.
module ccg_sweep_ctrl
  import ccg_sweep_ctrl_pkg::*;
#(
  parameter int N_IN       = 5,
  parameter int N_OUT      = 12,
  parameter int SETTLE_CYC = 1
) (
  input logic             clk,
  input logic             rst_n,
  ccg_sweep_ctrl_if.slave bus
);

  localparam int                  CNT_W       = N_IN + 1;
  localparam logic [N_IN-1:0]     X_LAST      = {N_IN{1'b1}};
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  state_e                state_q, state_d;
  logic [N_IN-1:0]       x_vec_q, x_vec_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [CNT_W-1:0]      mm_cnt_q, mm_cnt_d;
  logic [N_IN-1:0]       ff_vec_q, ff_vec_d;
  logic [N_OUT-1:0]      ff_mask_q, ff_mask_d;

  logic [N_OUT-1:0]      diff;
  logic                  misr_init;
  logic                  misr_en;
  logic [MISR_W-1:0]     misr_din;
  logic [MISR_W-1:0]     misr_sig;

  assign diff = bus.f_ref ^ bus.f_dut;

  // f_dut zero-extended (or truncated) to the MISR width
  generate
    for (genvar gi = 0; gi < MISR_W; gi++) begin : g_din
      if (gi < N_OUT) begin : g_bit
        assign misr_din[gi] = bus.f_dut[gi];
      end else begin : g_zero
        assign misr_din[gi] = 1'b0;
      end
    end
  endgenerate

  // Sweep sequencing and result bookkeeping; abort overrides everything outside IDLE
  always_comb begin
    state_d      = state_q;
    x_vec_d      = x_vec_q;
    settle_cnt_d = settle_cnt_q;
    aborted_d    = aborted_q;
    mm_cnt_d     = mm_cnt_q;
    ff_vec_d     = ff_vec_q;
    ff_mask_d    = ff_mask_q;
    done_d       = 1'b0;
    misr_init    = 1'b0;
    misr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start beats a simultaneous abort; abort alone is ignored here
        if (bus.start) begin
          x_vec_d   = '0;
          mm_cnt_d  = '0;
          ff_vec_d  = '0;
          ff_mask_d = '0;
          aborted_d = 1'b0;
          misr_init = 1'b1;
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        settle_cnt_d = SETTLE_LOAD;
        state_d      = (SETTLE_CYC > 0) ? ST_SETTLE : ST_CAPTURE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end
      ST_CAPTURE: begin
        misr_en = 1'b1;
        if (diff != '0) begin
          mm_cnt_d = mm_cnt_q + CNT_W'(1);
          if (mm_cnt_q == '0) begin
            ff_vec_d  = x_vec_q;
            ff_mask_d = diff;
          end
        end
        // The last vector stays on x_vec so the sweep end is visible
        if (x_vec_q == X_LAST) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else begin
          x_vec_d = x_vec_q + N_IN'(1);
          state_d = ST_DRIVE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort drops this cycle's capture entirely and returns to IDLE
    if (state_q != ST_IDLE && bus.abort) begin
      state_d      = ST_IDLE;
      aborted_d    = 1'b1;
      done_d       = 1'b0;
      misr_en      = 1'b0;
      x_vec_d      = x_vec_q;
      settle_cnt_d = settle_cnt_q;
      mm_cnt_d     = mm_cnt_q;
      ff_vec_d     = ff_vec_q;
      ff_mask_d    = ff_mask_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Controller state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_vec_q      <= '0;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      mm_cnt_q     <= '0;
      ff_vec_q     <= '0;
      ff_mask_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_vec_q      <= x_vec_d;
      settle_cnt_q <= settle_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      mm_cnt_q     <= mm_cnt_d;
      ff_vec_q     <= ff_vec_d;
      ff_mask_q    <= ff_mask_d;
    end
  end

  ccg_misr16 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (misr_init),
    .en    (misr_en),
    .din   (misr_din),
    .sig   (misr_sig)
  );

  assign bus.x_vec           = x_vec_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.aborted         = aborted_q;
  assign bus.mismatch_cnt    = mm_cnt_q;
  assign bus.first_fail_vec  = ff_vec_q;
  assign bus.first_fail_mask = ff_mask_q;
  assign bus.signature       = misr_sig;

endmodule
